// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one downstream memory port between the instruction
// and data request ports, with one-deep request buffering per side.
module mem_arbiter #(
  parameter int unsigned D_STREAK_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned STREAK_W = 4;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state, state_nxt;
  req_t                ipend, ipend_nxt, dpend, dpend_nxt;
  logic                ipend_v, ipend_v_nxt, dpend_v, dpend_v_nxt;
  logic [STREAK_W-1:0] d_streak, d_streak_nxt;
  req_t                i_live, d_live, i_sel, d_sel;
  logic                i_cand, d_cand, grant_i, grant_d;

  // Live pulse wins over its buffer when selecting the issue source
  always_comb begin
    i_live = {imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
    d_live = {dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
    i_sel  = imemory_valid ? i_live : ipend;
    d_sel  = dmemory_valid ? d_live : dpend;
    i_cand = imemory_valid | ipend_v;
    d_cand = dmemory_valid | dpend_v;
  end

  always_comb begin
    state_nxt     = state;
    ipend_nxt     = ipend;
    ipend_v_nxt   = ipend_v;
    dpend_nxt     = dpend;
    dpend_v_nxt   = dpend_v;
    d_streak_nxt  = d_streak;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    mem_valid     = 1'b0;
    {mem_instr, mem_addr, mem_wdata, mem_wstrb} = '0;
    imemory_ready = 1'b0;
    imemory_rdata = '0;
    dmemory_ready = 1'b0;
    dmemory_rdata = '0;

    case (state)
      IDLE: begin
        // Reset gating keeps every output low while reset is held
        if (reset) begin
          grant_d = d_cand && (!i_cand || (d_streak != STREAK_W'(D_STREAK_MAX)));
          grant_i = i_cand && !grant_d;
        end
        if (grant_d) begin
          mem_valid   = 1'b1;
          {mem_instr, mem_addr, mem_wdata, mem_wstrb} = d_sel;
          dpend_v_nxt = 1'b0;
          state_nxt   = BUSY_D;
          if (!i_cand)
            d_streak_nxt = '0;
          else if (d_streak != {STREAK_W{1'b1}})
            d_streak_nxt = d_streak + STREAK_W'(1);
        end else if (grant_i) begin
          mem_valid    = 1'b1;
          {mem_instr, mem_addr, mem_wdata, mem_wstrb} = i_sel;
          ipend_v_nxt  = 1'b0;
          state_nxt    = BUSY_I;
          d_streak_nxt = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          imemory_ready = 1'b1;
          imemory_rdata = mem_rdata;
          state_nxt     = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          dmemory_ready = 1'b1;
          dmemory_rdata = mem_rdata;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Any live pulse not issued this cycle is parked in its buffer
    if (imemory_valid && !grant_i) begin
      ipend_nxt   = i_live;
      ipend_v_nxt = 1'b1;
    end
    if (dmemory_valid && !grant_d) begin
      dpend_nxt   = d_live;
      dpend_v_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ipend    <= '0;
      ipend_v  <= 1'b0;
      dpend    <= '0;
      dpend_v  <= 1'b0;
      d_streak <= '0;
    end else begin
      state    <= state_nxt;
      ipend    <= ipend_nxt;
      ipend_v  <= ipend_v_nxt;
      dpend    <= dpend_nxt;
      dpend_v  <= dpend_v_nxt;
      d_streak <= d_streak_nxt;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-to-one arbiter sharing one downstream memory port (e.g. the avl bridge) between the CPU instruction and data request ports.
- Both upstream sides and the downstream side use the native valid/instr/addr/wdata/wstrb -> rdata/ready protocol.
- Buffers one request per requester while the port is busy.
- Grants data over instruction by default, with a bounded-starvation override for instruction fetch.

Parameters:
- D_STREAK_MAX, 4: number of consecutive data grants allowed while an instruction request waits; range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- imemory_valid  in  1  instruction-side request pulse
- imemory_instr  in  1  request is an instruction fetch
- imemory_addr  in  32  request address
- imemory_wdata  in  32  write data
- imemory_wstrb  in  4  byte write strobes; 0 means read
- imemory_rdata  out  32  read data
- imemory_ready  out  1  completion pulse
- dmemory_valid/instr/addr/wdata/wstrb/rdata/ready: same widths and directions as the instruction side, for the data side
- mem_valid  out  1  downstream request pulse
- mem_instr  out  1  forwarded instr flag
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_wstrb  out  4  forwarded strobes
- mem_rdata  in  32  downstream read data
- mem_ready  in  1  downstream completion pulse

Behaviour:
- Protocol:
  - valid is a single-cycle pulse; the request fields are valid only in that cycle.
  - A requester must not pulse valid again until it has seen its ready.
  - Downstream accepts exactly one outstanding request.
  - mem_ready is a single-cycle pulse.
- State machine: IDLE, BUSY_I, BUSY_D. On reset (asynchronous, reset==0):
  - state = IDLE
  - both pending buffers invalid
  - d_streak = 0
  - all outputs 0
- Pending buffers:
  - ipend and dpend each hold {instr, addr, wdata, wstrb} plus a valid bit.
  - Any upstream valid pulse that is not issued downstream in the same cycle is captured into its buffer.
- Candidates in IDLE: the instruction candidate is ipend or a live imemory_valid; the data candidate is the same for the data side. The live pulse takes precedence over its buffer, though both never coexist legally.
- Grant rules in IDLE:
  - Only one candidate: grant it.
  - Both candidates: grant data, unless d_streak == D_STREAK_MAX, in which case grant instruction.
- Issue:
  - On a grant, mem_valid=1 in the same cycle, and mem_* are driven combinationally from the selected source (live or buffer). This gives zero added latency when idle.
  - Next state is BUSY_I or BUSY_D.
  - The granted buffer is cleared; the loser's live pulse is captured into its buffer.
- BUSY_x:
  - mem_valid=0.
  - Upstream pulses are captured into the buffers.
  - On mem_ready: the owner's *_ready=1 and *_rdata=mem_rdata in the same cycle (combinational); the other requester's ready=0 and rdata=0; next state IDLE.
  - Buffered requests issue in the following IDLE cycle, so back-to-back issue has a one-cycle bubble.
- Outputs outside a completion cycle: *_rdata=0 and *_ready=0. In IDLE, mem_* fields are 0 when there is no grant.
- d_streak (4 bits):
  - Granting data while an instruction candidate exists: saturating increment.
  - Granting instruction: reset to 0.
  - Granting data with no instruction candidate: reset to 0.
- mem_ready while IDLE (spurious, or after a mid-operation reset) is ignored; no upstream ready is generated.
- Reset mid-transaction: state and buffers are cleared immediately, and the lost requests are never completed. The CPU is reset by the same signal.
- A simultaneous mem_ready and a new upstream pulse in a BUSY cycle: the pulse is buffered, then issued in the next IDLE cycle.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs -> mem_valid=0, imemory_ready=0, dmemory_ready=0. Release, then imemory_valid pulse addr=0x100 -> mem_valid=1, mem_addr=0x100 in the same cycle.
- Collision: imemory_valid (0x200) and dmemory_valid (0x8000_0010, wstrb=0xF) in the same cycle -> data issued first. mem_ready -> dmemory_ready pulse. Next cycle mem_addr=0x200 issued. mem_ready with rdata=0xDEADBEEF -> imemory_rdata=0xDEADBEEF, imemory_ready=1.
- Busy buffering: data issued; while BUSY_D, pulse imemory_valid 0x300 -> no mem_valid until mem_ready. Then 0x300 issues exactly one cycle after mem_ready.
- Fairness: instruction request waiting; data re-requests immediately after each completion -> exactly 4 data grants, then the instruction grant, then d_streak=0.
- Spurious and mid-operation reset: issue data, assert reset=0 before mem_ready, release, then pulse mem_ready -> neither upstream ready asserts, and the buffers stay empty.
